// File: rtl/arb4_rr_encoder.sv
// arb4_rr_encoder: four-requester round-robin arbiter with a registered one-hot grant, its encoded index and a valid flag.
// Optional macro ARB_HOLD_LIMIT_EN forces rotation after MAX_HOLD consecutive grant cycles.
module arb4_rr_encoder #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       busy
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** HOLD_W) <= MAX_HOLD) begin : g_param_check
    $error("arb4_rr_encoder: illegal MAX_HOLD/HOLD_W combination");
  end

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] last_q, last_d;

  logic [3:0] owner_oh;
  logic       owner_req;
  logic [3:0] others;
  logic [3:0] search_req;
  logic [1:0] search_last;
  logic       pick_vld;
  logic [1:0] pick_idx;
  logic [1:0] cand;
  logic       preempt;

  assign owner_oh  = 4'b0001 << idx_q;
  assign owner_req = req[idx_q];
  assign others    = req & ~owner_oh;

  // While granted, the search starts after the owner and never considers it.
  assign search_req  = (state_q == ST_GRANT) ? others : req;
  assign search_last = (state_q == ST_GRANT) ? idx_q  : last_q;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    cand     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = search_last + k[1:0];
      if (!pick_vld && search_req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              take;

  assign preempt = (state_q == ST_GRANT) && owner_req && en && (|others) &&
                   (hold_cnt_q == HOLD_LAST);
  assign take    = (state_d == ST_GRANT) && ((state_q == ST_IDLE) || (idx_d != idx_q));

  // Counter saturates at HOLD_LAST so a lone owner stays preemptible as soon as a rival appears.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (take) begin
      hold_cnt_d = '0;
    end else if ((state_q == ST_GRANT) && owner_req && (hold_cnt_q != HOLD_LAST)) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (en && pick_vld) begin
          state_d = ST_GRANT;
          grant_d = 4'b0001 << pick_idx;
          idx_d   = pick_idx;
        end
      end
      ST_GRANT: begin
        if (!owner_req || preempt) begin
          last_d = idx_q;
          if (en && pick_vld) begin
            grant_d = 4'b0001 << pick_idx;
            idx_d   = pick_idx;
          end else begin
            state_d = ST_IDLE;
            grant_d = 4'b0000;
            idx_d   = 2'd0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 4'b0000;
      idx_q   <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = |grant_q;
  assign busy        = (state_q == ST_GRANT);

endmodule

// File: tb/tb_arb4_rr_encoder.sv
// Bench for arb4_rr_encoder: directed vector table, hand sequences for reset and hold limit, randomized run against a model.
module tb_arb4_rr_encoder;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       busy;

  arb4_rr_encoder #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] idx;
    logic       v;
  } vec_t;

  vec_t vt[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: owner number (-1 = none), last served, and cycles the current grant has been visible.
  int m_owner, m_last, m_held;

  function automatic int rr_next(logic [3:0] r, int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_last  = 3;
    m_held  = 0;
  endfunction

  function automatic void model_edge(logic e, logic [3:0] r);
    logic       rel;
    logic [3:0] rest;
    if (m_owner < 0) begin
      if (e) m_owner = rr_next(r, m_last);
      m_held = 1;
    end else begin
      rest = r;
      rest[m_owner] = 1'b0;
      rel = !r[m_owner];
`ifdef ARB_HOLD_LIMIT_EN
      if (r[m_owner] && e && m_held >= MAX_HOLD && rest != 4'b0000) rel = 1'b1;
`endif
      if (rel) begin
        m_last  = m_owner;
        m_owner = e ? rr_next(rest, m_owner) : -1;
        m_held  = 1;
      end else begin
        m_held = m_held + 1;
      end
    end
  endfunction

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] ei, input logic ev);
    n_chk++;
    if (grant === eg && grant_idx === ei && grant_valid === ev && busy === ev) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got grant=%b idx=%0d valid=%b busy=%b, want grant=%b idx=%0d valid=%b busy=%b",
               name, grant, grant_idx, grant_valid, busy, eg, ei, ev, ev);
    end
  endtask

  task automatic check_model(input string name);
    logic [3:0] eg;
    logic [1:0] ei;
    eg = 4'b0000;
    ei = 2'd0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ei = 2'(m_owner);
    end
    check(name, eg, ei, m_owner >= 0);
  endtask

  task automatic step(input logic e, input logic [3:0] r);
    en  = e;
    req = r;
    @(posedge clk);
    model_edge(e, r);
    @(negedge clk);
  endtask

  function automatic void add(input logic e, input logic [3:0] r, input logic [3:0] g, input logic [1:0] i);
    vt.push_back('{e, r, g, i, (g != 4'b0000)});
  endfunction

  logic       hold_en;
  logic [3:0] rnd_req;
  logic [1:0] exp_i;

  initial begin
`ifdef ARB_HOLD_LIMIT_EN
    hold_en = 1'b1;
`else
    hold_en = 1'b0;
`endif
    // Idle with no requests, then back-to-back hand-off from 1 to 3.
    for (int i = 0; i < 5; i++) add(1'b1, 4'b0000, 4'b0000, 2'd0);
    add(1'b1, 4'b1010, 4'b0010, 2'd1);
    add(1'b1, 4'b1010, 4'b0010, 2'd1);
    add(1'b1, 4'b1000, 4'b1000, 2'd3);
    add(1'b1, 4'b0000, 4'b0000, 2'd0);
    // All four requesting; each owner releases after two cycles.
    add(1'b1, 4'b1111, 4'b0001, 2'd0);
    add(1'b1, 4'b1111, 4'b0001, 2'd0);
    add(1'b1, 4'b1110, 4'b0010, 2'd1);
    add(1'b1, 4'b1111, 4'b0010, 2'd1);
    add(1'b1, 4'b1101, 4'b0100, 2'd2);
    add(1'b1, 4'b1111, 4'b0100, 2'd2);
    add(1'b1, 4'b1011, 4'b1000, 2'd3);
    add(1'b1, 4'b1111, 4'b1000, 2'd3);
    add(1'b1, 4'b0111, 4'b0001, 2'd0);
    // Owner 2 under en=0 keeps the grant, then release goes idle until en returns.
    add(1'b1, 4'b0100, 4'b0100, 2'd2);
    add(1'b0, 4'b0101, 4'b0100, 2'd2);
    add(1'b0, 4'b0101, 4'b0100, 2'd2);
    add(1'b0, 4'b0001, 4'b0000, 2'd0);
    add(1'b0, 4'b0001, 4'b0000, 2'd0);
    add(1'b1, 4'b0001, 4'b0001, 2'd0);
    add(1'b1, 4'b0000, 4'b0000, 2'd0);

    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;
    model_reset();
    #2;
    check("reset_state", 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      step(vt[i].en, vt[i].req);
      check($sformatf("vec%0d", i), vt[i].g, vt[i].idx, vt[i].v);
    end

    // Asynchronous reset between edges while requester 1 owns the grant.
    step(1'b1, 4'b0010);
    check("pre_reset_grant", 4'b0010, 2'd1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", 4'b0000, 2'd0, 1'b0);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 4'b1000);
    check("post_reset_req3", 4'b1000, 2'd3, 1'b1);
    step(1'b1, 4'b0000);
    check("post_reset_release", 4'b0000, 2'd0, 1'b0);

    // Requesters 0 and 3 held high: rotate every MAX_HOLD cycles only with the hold limit.
    for (int c = 0; c < 3 * MAX_HOLD; c++) begin
      step(1'b1, 4'b1001);
      exp_i = (hold_en && ((c / MAX_HOLD) % 2 == 1)) ? 2'd3 : 2'd0;
      check($sformatf("hold_rot%0d", c), 4'b0001 << exp_i, exp_i, 1'b1);
    end
    // Lone owner keeps the grant past the limit, then yields as soon as a rival appears.
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 4'b0001);
      check($sformatf("hold_alone%0d", c), 4'b0001, 2'd0, 1'b1);
    end
    step(1'b1, 4'b1001);
    exp_i = hold_en ? 2'd3 : 2'd0;
    check("hold_rival", 4'b0001 << exp_i, exp_i, 1'b1);
    step(1'b1, 4'b0000);
    check("hold_release", 4'b0000, 2'd0, 1'b0);

    // Randomized traffic against the model.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    rnd_req = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) rnd_req[b] = ~rnd_req[b];
      end
      step($urandom_range(0, 7) != 0, rnd_req);
      check_model($sformatf("rand%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
